// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | pipeline_hazard_ctrl: stage enables, bubble strobes and stall/flush        |
// | counters for a 5-stage pipeline with req/ack instruction and data memory.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module pipeline_hazard_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [4:0]       de_dst_reg,
   input  logic             de_mem_read,
   input  logic             em_take_branch,
   input  logic             em_mem_access,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             pc_wren,
   output logic             fd_wren,
   output logic             de_wren,
   output logic             em_wren,
   output logic             mw_wren,
   output logic             fd_flush,
   output logic             de_flush,
   output logic             em_flush,
   output logic             mw_flush,
   output logic             pc_sel_branch,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0]       c_st_boot    = 2'd0;
   localparam logic [1:0]       c_st_run     = 2'd1;
   localparam logic [1:0]       c_st_discard = 2'd2;
   localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

   logic [1:0]       r_state;
   logic [1:0]       w_next_state;
   logic             w_dmem_stall;
   logic             w_load_use;
   logic             w_stall_evt;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   assign w_dmem_stall = em_mem_access & ~dmem_ack;
   assign w_load_use   = de_mem_read & (de_dst_reg != 5'd0) &
                         ((id_uses_rs & (id_rs == de_dst_reg)) |
                          (id_uses_rt & (id_rt == de_dst_reg)));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= c_st_boot;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A fetch still outstanding after a redirect returns the old-path word;
   // DISCARD waits for that ack, even one arriving during a data stall.
   always_comb begin
      w_next_state = c_st_boot;
      case (r_state)
         c_st_boot:    w_next_state = c_st_run;
         c_st_run:     w_next_state = (!w_dmem_stall && em_take_branch && !imem_ack)
                                      ? c_st_discard : c_st_run;
         c_st_discard: w_next_state = imem_ack ? c_st_run : c_st_discard;
         default:      w_next_state = c_st_boot;
      endcase
   end

   always_comb begin
      imem_req      = 1'b0;
      dmem_req      = 1'b0;
      pc_wren       = 1'b0;
      fd_wren       = 1'b0;
      de_wren       = 1'b0;
      em_wren       = 1'b0;
      mw_wren       = 1'b0;
      fd_flush      = 1'b0;
      de_flush      = 1'b0;
      em_flush      = 1'b0;
      mw_flush      = 1'b0;
      pc_sel_branch = 1'b0;
      if (reset_n && (r_state == c_st_run || r_state == c_st_discard)) begin
         imem_req = 1'b1;
         dmem_req = em_mem_access;
         if (w_dmem_stall) begin
            mw_wren  = 1'b1;
            mw_flush = 1'b1;
         end else if (em_take_branch) begin
            pc_wren       = 1'b1;
            fd_wren       = 1'b1;
            de_wren       = 1'b1;
            em_wren       = 1'b1;
            mw_wren       = 1'b1;
            fd_flush      = 1'b1;
            de_flush      = 1'b1;
            em_flush      = 1'b1;
            pc_sel_branch = 1'b1;
         end else if (r_state == c_st_discard || (!w_load_use && !imem_ack)) begin
            fd_wren  = 1'b1;
            fd_flush = 1'b1;
            de_wren  = 1'b1;
            em_wren  = 1'b1;
            mw_wren  = 1'b1;
         end else if (w_load_use) begin
            de_wren  = 1'b1;
            de_flush = 1'b1;
            em_wren  = 1'b1;
            mw_wren  = 1'b1;
         end else begin
            pc_wren = 1'b1;
            fd_wren = 1'b1;
            de_wren = 1'b1;
            em_wren = 1'b1;
            mw_wren = 1'b1;
         end
      end
   end

   assign w_stall_evt = reset_n & (r_state != c_st_boot) & ~pc_wren;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_evt && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_cnt_one;
         end
         if (pc_sel_branch && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + c_cnt_one;
         end
      end
   end

   assign stall_cnt = reset_n ? r_stall_cnt : '0;
   assign flush_cnt = reset_n ? r_flush_cnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_pipeline_hazard_ctrl: directed vectors with hand-computed expectations. |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_pipeline_hazard_ctrl;

   localparam int CNT_W = 4;

   // {imem_req,dmem_req,pc,fd,de,em,mw_wren,fd,de,em,mw_flush,pc_sel_branch}
   localparam logic [11:0] c_zero  = 12'b0_0_00000_0000_0;
   localparam logic [11:0] c_norm  = 12'b1_0_11111_0000_0;
   localparam logic [11:0] c_lu    = 12'b1_0_00111_0100_0;
   localparam logic [11:0] c_redir = 12'b1_0_11111_1110_1;
   localparam logic [11:0] c_iwait = 12'b1_0_01111_1000_0;
   localparam logic [11:0] c_dstl  = 12'b1_1_00001_0001_0;
   localparam logic [11:0] c_dok   = 12'b1_1_11111_0000_0;

   logic             clk = 1'b0;
   logic             reset_n;
   logic [4:0]       id_rs, id_rt, de_dst_reg;
   logic             id_uses_rs, id_uses_rt, de_mem_read;
   logic             em_take_branch, em_mem_access, imem_ack, dmem_ack;
   logic             imem_req, dmem_req;
   logic             pc_wren, fd_wren, de_wren, em_wren, mw_wren;
   logic             fd_flush, de_flush, em_flush, mw_flush, pc_sel_branch;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [11:0]      w_out;

   int n_checks = 0;
   int n_errors = 0;

   pipeline_hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
      .de_dst_reg(de_dst_reg), .de_mem_read(de_mem_read),
      .em_take_branch(em_take_branch), .em_mem_access(em_mem_access),
      .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .imem_req(imem_req), .dmem_req(dmem_req),
      .pc_wren(pc_wren), .fd_wren(fd_wren), .de_wren(de_wren),
      .em_wren(em_wren), .mw_wren(mw_wren),
      .fd_flush(fd_flush), .de_flush(de_flush), .em_flush(em_flush), .mw_flush(mw_flush),
      .pc_sel_branch(pc_sel_branch), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   assign w_out = {imem_req, dmem_req, pc_wren, fd_wren, de_wren, em_wren, mw_wren,
                   fd_flush, de_flush, em_flush, mw_flush, pc_sel_branch};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      reset_n        = 1'b1;
      id_rs          = 5'd0;
      id_rt          = 5'd0;
      id_uses_rs     = 1'b0;
      id_uses_rt     = 1'b0;
      de_dst_reg     = 5'd0;
      de_mem_read    = 1'b0;
      em_take_branch = 1'b0;
      em_mem_access  = 1'b0;
      imem_ack       = 1'b1;
      dmem_ack       = 1'b1;
   endtask

   // Move to just after the next rising edge; inputs are then applied.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle before sampling.
   task automatic settle();
      #2;
   endtask

   task automatic load_use_rs5();
      de_mem_read = 1'b1;
      de_dst_reg  = 5'd5;
      id_rs       = 5'd5;
      id_uses_rs  = 1'b1;
   endtask

   initial begin
      clr();
      reset_n = 1'b0;
      @(posedge clk);
      step();
      settle();
      check("rst_out", 32'(w_out), 32'(c_zero));
      check("rst_stall", 32'(stall_cnt), 32'd0);
      check("rst_flush", 32'(flush_cnt), 32'd0);

      step(); clr(); settle();
      check("boot_out", 32'(w_out), 32'(c_zero));

      // T1: load-use on rs
      step(); clr(); load_use_rs5(); settle();
      check("t1_lu", 32'(w_out), 32'(c_lu));
      step(); clr(); settle();
      check("t1_after", 32'(w_out), 32'(c_norm));
      check("t1_stall", 32'(stall_cnt), 32'd1);

      // T2: r0 never stalls; rt path; rt not used
      step(); clr(); load_use_rs5(); de_dst_reg = 5'd0; id_rs = 5'd0; settle();
      check("t2_r0", 32'(w_out), 32'(c_norm));
      step(); clr(); de_mem_read = 1'b1; de_dst_reg = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1; settle();
      check("lu_rt", 32'(w_out), 32'(c_lu));
      step(); clr(); de_mem_read = 1'b1; de_dst_reg = 5'd7; id_rt = 5'd7; settle();
      check("lu_rt_unused", 32'(w_out), 32'(c_norm));
      check("lu_stall", 32'(stall_cnt), 32'd2);

      // T3: redirect with ack
      step(); clr(); em_take_branch = 1'b1; settle();
      check("t3_redir", 32'(w_out), 32'(c_redir));
      step(); clr(); settle();
      check("t3_run", 32'(w_out), 32'(c_norm));
      check("t3_flush", 32'(flush_cnt), 32'd1);

      // T4: three data wait-states
      for (int i = 0; i < 3; i++) begin
         step(); clr(); em_mem_access = 1'b1; dmem_ack = 1'b0; settle();
         check("t4_dstall", 32'(w_out), 32'(c_dstl));
      end
      step(); clr(); em_mem_access = 1'b1; settle();
      check("t4_resume", 32'(w_out), 32'(c_dok));
      check("t4_stall", 32'(stall_cnt), 32'd5);

      // IMEM wait alone, then together with load-use
      step(); clr(); imem_ack = 1'b0; settle();
      check("iwait", 32'(w_out), 32'(c_iwait));
      step(); clr(); imem_ack = 1'b0; load_use_rs5(); settle();
      check("iwait_lu", 32'(w_out), 32'(c_lu));
      step(); clr(); settle();
      check("iwait_stall", 32'(stall_cnt), 32'd7);

      // T5: redirect without ack, ack two cycles later
      step(); clr(); em_take_branch = 1'b1; imem_ack = 1'b0; settle();
      check("t5_redir", 32'(w_out), 32'(c_redir));
      step(); clr(); imem_ack = 1'b0; settle();
      check("t5_disc1", 32'(w_out), 32'(c_iwait));
      check("t5_flush", 32'(flush_cnt), 32'd2);
      step(); clr(); settle();
      check("t5_disc2", 32'(w_out), 32'(c_iwait));
      step(); clr(); settle();
      check("t5_run", 32'(w_out), 32'(c_norm));
      check("t5_stall", 32'(stall_cnt), 32'd9);

      // Ack arriving during a data stall in DISCARD is consumed
      step(); clr(); em_take_branch = 1'b1; imem_ack = 1'b0; settle();
      check("disc_redir", 32'(w_out), 32'(c_redir));
      step(); clr(); em_mem_access = 1'b1; dmem_ack = 1'b0; settle();
      check("disc_dstall", 32'(w_out), 32'(c_dstl));
      step(); clr(); settle();
      check("disc_consumed", 32'(w_out), 32'(c_norm));
      check("disc_stall", 32'(stall_cnt), 32'd10);
      check("disc_flush", 32'(flush_cnt), 32'd3);

      // Stall counter saturates at 15
      for (int i = 0; i < 8; i++) begin
         step(); clr(); imem_ack = 1'b0; settle();
      end
      step(); clr(); settle();
      check("sat_stall", 32'(stall_cnt), 32'd15);

      // T6: redirect wins over load-use; reset in DISCARD
      step(); clr(); em_take_branch = 1'b1; imem_ack = 1'b0; load_use_rs5(); settle();
      check("t6_redir", 32'(w_out), 32'(c_redir));
      step(); clr(); imem_ack = 1'b0; settle();
      check("t6_disc", 32'(w_out), 32'(c_iwait));
      check("t6_stall_sat", 32'(stall_cnt), 32'd15);
      check("t6_flush", 32'(flush_cnt), 32'd4);
      step(); clr(); reset_n = 1'b0; imem_ack = 1'b0; settle();
      check("t6_rst_out", 32'(w_out), 32'(c_zero));
      check("t6_rst_stall", 32'(stall_cnt), 32'd0);
      check("t6_rst_flush", 32'(flush_cnt), 32'd0);
      step(); clr(); imem_ack = 1'b0; settle();
      check("t6_boot", 32'(w_out), 32'(c_zero));
      step(); clr(); settle();
      check("t6_run", 32'(w_out), 32'(c_norm));
      check("t6_cnt_clr", 32'(stall_cnt), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
